// File: rtl/scoreboard_hazard_ctrl_if.sv
// rtl/scoreboard_hazard_ctrl_if.sv - ID-stage hazard request and stall/issue response bundle
interface scoreboard_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int CNT_W          = 4,
    parameter int STALL_CNT_W    = 32
);
    logic                      id_valid_i;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_i;
    logic                      rs1_used_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_i;
    logic                      rs2_used_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
    logic                      rd_we_i;
    logic [CNT_W-1:0]          lat_i;
    logic                      flush_i;
    logic                      backend_stall_i;
    logic                      stall_o;
    logic                      issue_o;
    logic [NUM_REGS-1:0]       pending_o;
    logic [STALL_CNT_W-1:0]    stall_cnt_o;

    modport master (
        output id_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
               rd_addr_i, rd_we_i, lat_i, flush_i, backend_stall_i,
        input  stall_o, issue_o, pending_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, rs1_addr_i, rs1_used_i, rs2_addr_i, rs2_used_i,
               rd_addr_i, rd_we_i, lat_i, flush_i, backend_stall_i,
        output stall_o, issue_o, pending_o, stall_cnt_o
    );
endinterface

// File: rtl/scoreboard_hazard_ctrl.sv
// rtl/scoreboard_hazard_ctrl.sv - per-register countdown scoreboard gating ID->EX issue
module scoreboard_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int MAX_LAT        = 8,
    parameter int STALL_CNT_W    = 32,
    localparam int CNT_W         = $clog2(MAX_LAT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scoreboard_hazard_ctrl_if.slave id_if
);
    // cnt[r] = cycles until a consumer of xr may enter EX; 0 means nothing in flight
    logic [CNT_W-1:0]       cnt [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic [CNT_W-1:0] l_eff;
    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rd;
    logic             rs1_ok;
    logic             rs2_ok;
    logic             rd_ok;
    logic             raw;
    logic             waw;
    logic             stall;
    logic             issue;
    logic             alloc;

    always_comb begin
        l_eff = id_if.lat_i;
        if (id_if.lat_i == '0) begin
            l_eff = CNT_W'(1);
        end else if (id_if.lat_i > CNT_W'(MAX_LAT)) begin
            l_eff = CNT_W'(MAX_LAT);
        end
    end

    // Out-of-range or x0 addresses never carry a hazard
    assign rs1_ok = (id_if.rs1_addr_i != '0) && (int'(id_if.rs1_addr_i) < NUM_REGS);
    assign rs2_ok = (id_if.rs2_addr_i != '0) && (int'(id_if.rs2_addr_i) < NUM_REGS);
    assign rd_ok  = (id_if.rd_addr_i  != '0) && (int'(id_if.rd_addr_i)  < NUM_REGS);

    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (int'(id_if.rs1_addr_i) == r) cnt_rs1 = cnt[r];
            if (int'(id_if.rs2_addr_i) == r) cnt_rs2 = cnt[r];
            if (int'(id_if.rd_addr_i)  == r) cnt_rd  = cnt[r];
        end
    end

    always_comb begin
        raw = (id_if.rs1_used_i && rs1_ok && (cnt_rs1 > CNT_W'(1))) ||
              (id_if.rs2_used_i && rs2_ok && (cnt_rs2 > CNT_W'(1)));
        // A new writer must not complete before an older write to the same register
        waw   = id_if.rd_we_i && rd_ok && (cnt_rd > l_eff);
        stall = id_if.backend_stall_i ||
                (id_if.id_valid_i && !id_if.flush_i && (raw || waw));
        issue = id_if.id_valid_i && !id_if.flush_i && !stall;
        alloc = issue && id_if.rd_we_i && rd_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (!id_if.backend_stall_i) begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - CNT_W'(1);
                    end
                end
            end
            if (alloc) begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (int'(id_if.rd_addr_i) == r) begin
                        cnt[r] <= l_eff;
                    end
                end
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    always_comb begin
        id_if.pending_o = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            id_if.pending_o[r] = (cnt[r] != '0);
        end
    end

    assign id_if.stall_o     = stall;
    assign id_if.issue_o     = issue;
    assign id_if.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_scoreboard_hazard_ctrl.sv
// tb/tb_scoreboard_hazard_ctrl.sv - directed and randomized checks of the hazard scoreboard
module tb_scoreboard_hazard_ctrl;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int ML = 8;
    localparam int CW = 4;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Reference model: remaining cycles per register, plus stall count
    int          mcnt [NR];
    logic [31:0] mstall;

    scoreboard_hazard_ctrl_if #(.REG_ADDR_WIDTH(AW), .NUM_REGS(NR), .CNT_W(CW), .STALL_CNT_W(SW)) sb_if ();

    scoreboard_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .NUM_REGS(NR), .MAX_LAT(ML), .STALL_CNT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .id_if (sb_if)
    );

    always #5 clk = ~clk;

    function automatic int m_leff();
        int l = int'(sb_if.lat_i);
        if (l == 0) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    function automatic bit m_stall();
        bit raw, waw;
        raw = (sb_if.rs1_used_i && sb_if.rs1_addr_i != 0 && mcnt[sb_if.rs1_addr_i] > 1) ||
              (sb_if.rs2_used_i && sb_if.rs2_addr_i != 0 && mcnt[sb_if.rs2_addr_i] > 1);
        waw = sb_if.rd_we_i && sb_if.rd_addr_i != 0 && mcnt[sb_if.rd_addr_i] > m_leff();
        return sb_if.backend_stall_i || (sb_if.id_valid_i && !sb_if.flush_i && (raw || waw));
    endfunction

    function automatic bit m_issue();
        return sb_if.id_valid_i && !sb_if.flush_i && !m_stall();
    endfunction

    function automatic logic [NR-1:0] m_pending();
        logic [NR-1:0] p = '0;
        for (int r = 1; r < NR; r++) p[r] = (mcnt[r] > 0);
        return p;
    endfunction

    function automatic void m_update();
        bit st = m_stall();
        bit is = m_issue();
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) mcnt[r] = 0;
            mstall = 0;
            return;
        end
        if (!sb_if.backend_stall_i)
            for (int r = 1; r < NR; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
        if (is && sb_if.rd_we_i && sb_if.rd_addr_i != 0) mcnt[sb_if.rd_addr_i] = m_leff();
        if (st && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
    endfunction

    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid_i = 0; sb_if.rs1_addr_i = 0; sb_if.rs1_used_i = 0;
        sb_if.rs2_addr_i = 0; sb_if.rs2_used_i = 0; sb_if.rd_addr_i = 0;
        sb_if.rd_we_i = 0; sb_if.lat_i = 0; sb_if.flush_i = 0; sb_if.backend_stall_i = 0;
    endtask

    task automatic writer(input int rd, input int lat);
        idle();
        sb_if.id_valid_i = 1; sb_if.rd_addr_i = AW'(rd); sb_if.rd_we_i = 1; sb_if.lat_i = CW'(lat);
    endtask

    task automatic reader(input int rs);
        idle();
        sb_if.id_valid_i = 1; sb_if.rs1_addr_i = AW'(rs); sb_if.rs1_used_i = 1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (sb_if.pending_o !== '0 || sb_if.stall_cnt_o !== '0 || sb_if.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL reset pending=%h stall_cnt=%0d stall=%b exp 0/0/0",
                     sb_if.pending_o, sb_if.stall_cnt_o, sb_if.stall_o);
        end
    endtask

    task automatic test_alu_forward();
        do_reset();
        writer(5, 1);
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b1) begin
            bad++; $display("FAIL alu_prod stall=%b issue=%b exp 0/1", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        reader(5);
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b1) begin
            bad++; $display("FAIL alu_cons stall=%b issue=%b exp 0/1", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (sb_if.stall_cnt_o !== 32'd0) begin
            bad++; $display("FAIL alu_stall_cnt got=%0d exp=0", sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        writer(6, 2);
        tick();
        reader(6);
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b1 || sb_if.issue_o !== 1'b0) begin
            bad++; $display("FAIL load_stall stall=%b issue=%b exp 1/0", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b1) begin
            bad++; $display("FAIL load_issue stall=%b issue=%b exp 0/1", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (sb_if.stall_cnt_o !== 32'd1) begin
            bad++; $display("FAIL load_stall_cnt got=%0d exp=1", sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_long_with_backend();
        int  stalls = 0;
        bit  done = 0;
        do_reset();
        writer(7, 5);
        tick();
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            reader(7);
            sb_if.backend_stall_i = (cyc == 1 || cyc == 2);
            @(negedge clk);
            if (sb_if.issue_o) done = 1;
            else if (sb_if.stall_o) stalls++;
            tick();
        end
        idle();
        @(negedge clk);
        total++;
        if (!done || stalls != 6) begin
            bad++; $display("FAIL long_stalls got=%0d done=%b exp 6", stalls, done);
        end
        total++;
        if (sb_if.stall_cnt_o !== 32'd6) begin
            bad++; $display("FAIL long_stall_cnt got=%0d exp=6", sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_waw();
        int  stalls = 0;
        bit  done = 0;
        int  pend_bad = 0;
        do_reset();
        writer(8, 5);
        tick();
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            writer(8, 1);
            @(negedge clk);
            if (sb_if.pending_o[8] !== 1'b1) pend_bad++;
            if (sb_if.issue_o) done = 1;
            else if (sb_if.stall_o) stalls++;
            tick();
        end
        idle();
        @(negedge clk);
        total++;
        if (!done || stalls != 4) begin
            bad++; $display("FAIL waw_stalls got=%0d done=%b exp 4", stalls, done);
        end
        total++;
        if (pend_bad != 0 || sb_if.pending_o[8] !== 1'b1) begin
            bad++; $display("FAIL waw_pending drops=%0d now=%b exp 0/1", pend_bad, sb_if.pending_o[8]);
        end
    endtask

    task automatic test_x0_and_flush();
        do_reset();
        writer(0, 5);
        tick();
        reader(0);
        @(negedge clk);
        total++;
        if (sb_if.pending_o !== '0 || sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b1) begin
            bad++; $display("FAIL x0 pending=%h stall=%b issue=%b exp 0/0/1",
                            sb_if.pending_o, sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        writer(9, 5);
        tick();
        reader(9);
        sb_if.flush_i = 1;
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b0) begin
            bad++; $display("FAIL flush stall=%b issue=%b exp 0/0", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        idle();
    endtask

    task automatic test_lat_clamp_and_reset();
        int stalls = 0;
        bit done = 0;
        do_reset();
        writer(10, 0);
        tick();
        reader(10);
        @(negedge clk);
        total++;
        if (sb_if.stall_o !== 1'b0 || sb_if.issue_o !== 1'b1) begin
            bad++; $display("FAIL lat0 stall=%b issue=%b exp 0/1", sb_if.stall_o, sb_if.issue_o);
        end
        tick();
        writer(11, 15);
        tick();
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            reader(11);
            @(negedge clk);
            if (sb_if.issue_o) done = 1;
            else if (sb_if.stall_o) stalls++;
            tick();
        end
        total++;
        if (!done || stalls != 7) begin
            bad++; $display("FAIL lat15 stalls got=%0d done=%b exp 7", stalls, done);
        end
        writer(12, 5);
        tick();
        idle();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        total++;
        if (sb_if.pending_o !== '0 || sb_if.stall_cnt_o !== '0) begin
            bad++; $display("FAIL mid_reset pending=%h stall_cnt=%0d exp 0/0",
                            sb_if.pending_o, sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sb_if.id_valid_i      = ($urandom_range(0, 3) != 0);
            sb_if.rs1_addr_i      = AW'($urandom_range(0, 7));
            sb_if.rs1_used_i      = $urandom_range(0, 1);
            sb_if.rs2_addr_i      = AW'($urandom_range(0, 7));
            sb_if.rs2_used_i      = $urandom_range(0, 1);
            sb_if.rd_addr_i       = AW'($urandom_range(0, 7));
            sb_if.rd_we_i         = $urandom_range(0, 1);
            sb_if.lat_i           = CW'($urandom_range(0, 15));
            sb_if.flush_i         = ($urandom_range(0, 7) == 0);
            sb_if.backend_stall_i = ($urandom_range(0, 7) == 0);
            rst_n                 = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            total++;
            if (sb_if.stall_o !== m_stall() || sb_if.issue_o !== m_issue()) begin
                bad++; $display("FAIL rnd_ctl i=%0d stall=%b issue=%b exp %b/%b",
                                i, sb_if.stall_o, sb_if.issue_o, m_stall(), m_issue());
            end
            total++;
            if (sb_if.pending_o !== m_pending() || sb_if.stall_cnt_o !== mstall) begin
                bad++; $display("FAIL rnd_state i=%0d pending=%h cnt=%0d exp %h/%0d",
                                i, sb_if.pending_o, sb_if.stall_cnt_o, m_pending(), mstall);
            end
            tick();
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        mstall = 0;
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_long_with_backend();
        test_waw();
        test_x0_and_flush();
        test_lat_clamp_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
